// File: rtl/nes_pad_pkg.sv
// Shared constants and types for the NES pad responder and its console-side partner.
package nes_pad_pkg;

    // Number of bits in one pad frame
    localparam int NES_BITS = 8;

    // Bit positions of each button inside the parallel button vector
    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    // Responder frame states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } pad_state_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous level, plus a delay flop that
// turns the synchronised level into a single-cycle rising-edge strobe.
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic s,
    output logic rise
);

    logic meta;
    logic dly;

    // Metastability chain followed by one extra stage for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            s    <= 1'b0;
            dly  <= 1'b0;
        end else begin
            meta <= d;
            s    <= meta;
            dly  <= s;
        end
    end

    assign rise = s & ~dly;

endmodule

// File: rtl/nes_pad_responder.sv
// Controller side of the NES serial pad link: captures the buttons while the
// console holds latch, then shifts them out active-low, one bit per pulse.
module nes_pad_responder
    import nes_pad_pkg::*;
#(
    parameter logic FILL_BIT     = 1'b0,
    parameter int   IDLE_TIMEOUT = 1000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                latch_in,
    input  logic                pulse_in,
    input  logic [NES_BITS-1:0] buttons,
    output logic                data_out,
    output logic [3:0]          bit_idx,
    output logic                frame_done,
    output logic                pad_idle
);

    localparam int CW = $clog2(IDLE_TIMEOUT + 1);

    logic latch_s;
    logic latch_rise;
    logic pulse_s;
    logic pulse_rise;
    logic unused_pulse_s;

    pad_state_t          state;
    pad_state_t          state_nx;
    logic [NES_BITS-1:0] sr;
    logic [NES_BITS-1:0] sr_nx;
    logic [3:0]          idx_nx;
    logic                fd_nx;
    logic [CW-1:0]       idle_cnt;

    sync_edge u_latch_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (latch_in),
        .s    (latch_s),
        .rise (latch_rise)
    );

    sync_edge u_pulse_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (pulse_in),
        .s    (pulse_s),
        .rise (pulse_rise)
    );

    // Only the pulse edge matters; its synchronised level is not needed here
    assign unused_pulse_s = pulse_s;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and datapath decisions; latch always wins over a pulse edge
    always_comb begin
        state_nx = state;
        sr_nx    = sr;
        idx_nx   = bit_idx;
        fd_nx    = 1'b0;
        if (latch_s) begin
            state_nx = LOAD;
            sr_nx    = ~buttons;
            idx_nx   = 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    state_nx = IDLE;
                end
                LOAD: begin
                    state_nx = SHIFT;
                end
                SHIFT: begin
                    if (pulse_rise) begin
                        sr_nx  = {FILL_BIT, sr[NES_BITS-1:1]};
                        idx_nx = bit_idx + 4'd1;
                        if (bit_idx == 4'(NES_BITS - 1)) begin
                            fd_nx    = 1'b1;
                            state_nx = DONE;
                        end
                    end
                end
                DONE: begin
                    if (pulse_rise) begin
                        sr_nx = {FILL_BIT, sr[NES_BITS-1:1]};
                    end
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

    // Shift register, bit counter and frame strobe; sr resets to all-released
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr         <= '1;
            bit_idx    <= 4'd0;
            frame_done <= 1'b0;
        end else begin
            sr         <= sr_nx;
            bit_idx    <= idx_nx;
            frame_done <= fd_nx;
        end
    end

    assign data_out = sr[0];

    // Idle monitor: cleared by each latch rising edge, saturates at the timeout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (latch_rise) begin
            idle_cnt <= '0;
        end else if (idle_cnt != CW'(IDLE_TIMEOUT)) begin
            idle_cnt <= idle_cnt + CW'(1);
        end
    end

    assign pad_idle = (idle_cnt == CW'(IDLE_TIMEOUT));

endmodule

// File: tb/tb_nes_pad_responder.sv
// Self-checking bench for nes_pad_responder: a frame-level reference model
// (captured vector + pulse count) is compared with the DUT every cycle.
module tb_nes_pad_responder;

    localparam int   T    = 100;
    localparam logic FILL = 1'b0;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       latch_in = 1'b0;
    logic       pulse_in = 1'b0;
    logic [7:0] buttons  = 8'hFF;
    logic       data_out;
    logic [3:0] bit_idx;
    logic       frame_done;
    logic       pad_idle;

    int errors  = 0;
    int checks  = 0;
    int fdCount = 0;

    nes_pad_responder #(
        .FILL_BIT     (FILL),
        .IDLE_TIMEOUT (T)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .latch_in   (latch_in),
        .pulse_in   (pulse_in),
        .buttons    (buttons),
        .data_out   (data_out),
        .bit_idx    (bit_idx),
        .frame_done (frame_done),
        .pad_idle   (pad_idle)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: what the pad holds (captured vector), how many pulses it
    // has answered, and cycles since the last latch rise. The console sees any
    // input change two clock edges after it is sampled.
    logic [7:0] mVec;
    int         mCount;
    bit         mLoaded;
    bit         mFd;
    int         mIdle;
    bit [2:0]   latH;
    bit [2:0]   pulH;

    // Model update on each edge, then compare shortly after the edge
    always @(posedge clk) begin
        bit actL, actRise, actLRise;
        logic expData;
        if (rst) begin
            mVec = 8'h00; mCount = 0; mLoaded = 0; mFd = 0; mIdle = 0;
            latH = 3'b000; pulH = 3'b000;
        end else begin
            actL     = latH[1];
            actRise  = pulH[1] & ~pulH[2];
            actLRise = latH[1] & ~latH[2];
            mFd = 0;
            if (actL) begin
                mLoaded = 1;
                mVec    = buttons;
                mCount  = 0;
            end else if (mLoaded && actRise && mCount < 8) begin
                mCount++;
                if (mCount == 8) mFd = 1;
            end
            if (actLRise) mIdle = 0;
            else if (mIdle < T) mIdle++;
            latH = {latH[1:0], latch_in};
            pulH = {pulH[1:0], pulse_in};
        end
        #1;
        if (!mLoaded) expData = 1'b1;
        else if (mCount < 8) expData = ~mVec[mCount];
        else expData = FILL;
        checkOutput("model data_out", 32'(data_out), 32'(expData));
        checkOutput("model bit_idx", 32'(bit_idx), 32'(mCount));
        checkOutput("model frame_done", 32'(frame_done), 32'(mFd));
        checkOutput("model pad_idle", 32'(pad_idle), 32'(mIdle == T));
        if (frame_done === 1'b1) fdCount++;
    end

    task automatic applyStimulus(input logic l, input logic p, input logic [7:0] b, input int n);
        latch_in = l;
        pulse_in = p;
        buttons  = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic latchFrame(input logic [7:0] b, input int w);
        applyStimulus(1'b1, 1'b0, b, w);
        applyStimulus(1'b0, 1'b0, b, 6);
    endtask

    task automatic pulseOnce(input logic [7:0] b, input int hi, input int lo);
        applyStimulus(1'b0, 1'b1, b, hi);
        applyStimulus(1'b0, 1'b0, b, lo);
    endtask

    logic [7:0] expSeq;

    initial begin
        // Reset held with all buttons pressed
        repeat (5) @(negedge clk);
        checkOutput("reset data_out", 32'(data_out), 32'd1);
        checkOutput("reset bit_idx", 32'(bit_idx), 32'd0);
        checkOutput("reset frame_done", 32'(frame_done), 32'd0);
        checkOutput("reset pad_idle", 32'(pad_idle), 32'd0);
        repeat (5) @(negedge clk);
        checkOutput("reset held data_out", 32'(data_out), 32'd1);
        rst = 1'b0;

        // Idle timeout, then recovery on the next latch
        applyStimulus(1'b0, 1'b0, 8'h85, 105);
        checkOutput("idle asserted", 32'(pad_idle), 32'd1);
        fdCount = 0;
        applyStimulus(1'b1, 1'b0, 8'h85, 3);
        checkOutput("idle cleared", 32'(pad_idle), 32'd0);
        applyStimulus(1'b1, 1'b0, 8'h85, 5);
        applyStimulus(1'b0, 1'b0, 8'h85, 6);

        // Normal frame: A, Select, Right
        expSeq = 8'b0111_1010;
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("frame bit %0d", i), 32'(data_out), 32'(expSeq[i]));
            pulseOnce(8'h85, 5, 5);
        end
        checkOutput("frame strobes", 32'(fdCount), 32'd1);
        checkOutput("frame bit_idx", 32'(bit_idx), 32'd8);
        checkOutput("frame fill", 32'(data_out), 32'(FILL));

        // Live tracking while latch is high
        applyStimulus(1'b1, 1'b0, 8'h00, 4);
        applyStimulus(1'b1, 1'b0, 8'h01, 4);
        applyStimulus(1'b0, 1'b0, 8'h01, 6);
        checkOutput("live first bit", 32'(data_out), 32'd0);

        // Overrun: ten pulses after one latch
        fdCount = 0;
        latchFrame(8'h3C, 6);
        for (int i = 0; i < 10; i++) begin
            pulseOnce(8'h3C, 5, 5);
            if (i >= 8) begin
                checkOutput($sformatf("overrun data %0d", i + 1), 32'(data_out), 32'd0);
                checkOutput($sformatf("overrun idx %0d", i + 1), 32'(bit_idx), 32'd8);
            end
        end
        checkOutput("overrun strobes", 32'(fdCount), 32'd1);

        // Latch and pulse raised together after three shifts
        latchFrame(8'hA1, 6);
        for (int i = 0; i < 3; i++) pulseOnce(8'hA1, 5, 5);
        checkOutput("collide pre idx", 32'(bit_idx), 32'd3);
        checkOutput("collide pre data", 32'(data_out), 32'd1);
        applyStimulus(1'b1, 1'b1, 8'hA1, 6);
        applyStimulus(1'b0, 1'b0, 8'hA1, 6);
        checkOutput("collide idx", 32'(bit_idx), 32'd0);
        checkOutput("collide data", 32'(data_out), 32'd0);

        // Reset mid-frame at bit 4, then a pulse without a fresh latch
        latchFrame(8'h0F, 6);
        for (int i = 0; i < 4; i++) pulseOnce(8'h0F, 5, 5);
        checkOutput("abort pre idx", 32'(bit_idx), 32'd4);
        rst = 1'b1;
        #1;
        checkOutput("abort data", 32'(data_out), 32'd1);
        checkOutput("abort idx", 32'(bit_idx), 32'd0);
        @(negedge clk);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'h0F, 3);
        pulseOnce(8'h0F, 5, 5);
        checkOutput("no latch idx", 32'(bit_idx), 32'd0);
        checkOutput("no latch data", 32'(data_out), 32'd1);

        // Randomised frames, gaps, mid-latch button changes and collisions
        for (int f = 0; f < 25; f++) begin
            logic [7:0] b;
            int np;
            b = 8'($urandom);
            applyStimulus(1'b0, 1'b0, b, (f % 5 == 0) ? 110 + int'($urandom_range(0, 40)) : int'($urandom_range(4, 20)));
            applyStimulus(1'b1, 1'b0, b, int'($urandom_range(4, 10)));
            if ($urandom_range(0, 2) == 0) begin
                b = 8'($urandom);
                applyStimulus(1'b1, 1'b0, b, int'($urandom_range(4, 8)));
            end
            applyStimulus(1'b0, 1'b0, b, int'($urandom_range(4, 8)));
            np = int'($urandom_range(0, 11));
            for (int p = 0; p < np; p++) begin
                pulseOnce(b, int'($urandom_range(4, 8)), int'($urandom_range(4, 8)));
                if ($urandom_range(0, 15) == 0) begin
                    applyStimulus(1'b1, 1'b1, b, 5);
                    applyStimulus(1'b0, 1'b0, b, 6);
                end
            end
        end

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nes_pad_responder.md
Name: nes_pad_responder

Overview:
- Emulates the controller side of the NES serial pad link: a 4021-style parallel-load/serial-out responder.
- Captures an 8-bit button vector while the console holds latch high.
- Shifts one bit per console pulse onto the active-low data line; the serial output feeds the console's data_in input.
- Used as a bench-free pad stand-in and as a hardware pad emulator driven by board switches.

Parameters:
- FILL_BIT, 1'b0, wire level driven after all 8 bits are shifted (genuine pad ties serial-in low).
- IDLE_TIMEOUT, 1000000, clk cycles without a latch rising edge before pad_idle asserts (40 ms at 25 MHz).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- latch_in  input  1  console latch, asynchronous to clk, active-high
- pulse_in  input  1  console clock/pulse, asynchronous to clk, shift on rising edge
- buttons  input  8  pressed=1; bit0 A, bit1 B, bit2 Select, bit3 Start, bit4 Up, bit5 Down, bit6 Left, bit7 Right
- data_out  output  1  serial wire level, active-low (0 = pressed)
- bit_idx  output  4  count of bits already shifted out since the last load, 0..8
- frame_done  output  1  one-cycle strobe when the 8th shift completes
- pad_idle  output  1  high when no latch has been seen for IDLE_TIMEOUT cycles

Behaviour:
- Reset (async, rst=1) values:
  - sync flops 0; shift register sr = 8'hFF (released); data_out=1
  - bit_idx=0; frame_done=0; pad_idle=0; idle counter 0; state IDLE
- Synchronisers:
  - latch_in and pulse_in each pass through 2 flops giving latch_s and pulse_s, plus 1 delay flop each giving latch_d and pulse_d.
  - pulse_rise = pulse_s & ~pulse_d; latch_rise = latch_s & ~latch_d.
- State machine:
  - IDLE: waiting. latch_s=1 -> LOAD.
  - LOAD: every cycle with latch_s=1, sr <= ~buttons and bit_idx <= 0, so button changes during latch are tracked live. latch_s=0 -> SHIFT.
  - SHIFT: on pulse_rise, sr <= {FILL_BIT, sr[7:1]} and bit_idx <= bit_idx+1. When bit_idx goes 7->8, assert frame_done for that one cycle and go to DONE.
  - DONE: further pulse_rise keeps shifting FILL_BIT; bit_idx saturates at 8 with no further strobe. latch_s=1 -> LOAD.
  - From any state, latch_s=1 forces LOAD. Latch overrides a simultaneous pulse_rise: the pulse is ignored and no shift occurs.
- data_out is sr[0], a flop output with no combinational path from any input.
- Latency: an input edge on latch_in/pulse_in occurring before clk edge n is acted on at clk edge n+2, and data_out shows the result after edge n+2. The same latency applies to a 0->1 on latch_in reaching data_out.
- Pulses shorter than 2 clk periods may be missed; the console contract is at least 4 clk high/low at 25 MHz.
- Idle monitor:
  - Counter cleared on latch_rise, otherwise increments, saturating at IDLE_TIMEOUT.
  - pad_idle = (counter == IDLE_TIMEOUT).
  - Counter width is $clog2(IDLE_TIMEOUT+1).
- Reset mid-frame returns everything to the reset values immediately. The next frame requires a fresh latch.

Decomposition:
- Package nes_pad_pkg:
  - button index constants BTN_A..BTN_RIGHT (0..7)
  - NES_BITS=8
  - state enum {IDLE, LOAD, SHIFT, DONE}
- One sub-module: sync_edge, a 2-flop synchroniser plus delay flop with a rise output. It is instantiated twice and is reusable by the console-side reader.

Test Plan:
- Reset: rst=1 for 100 ns with buttons=8'hFF -> data_out=1, bit_idx=0, frame_done=0, pad_idle=0, all held while rst=1.
- Normal frame: buttons=8'b1000_0101 (A, Select, Right); latch 12 us high then 8 pulses of 6 us -> data_out sequence before each pulse is 0,1,0,1,1,1,1,0. frame_done pulses once, bit_idx ends at 8, data_out=FILL_BIT (0).
- Live tracking: change buttons from 8'h00 to 8'h01 while latch is high -> after latch falls, first bit on data_out is 0 (A pressed).
- Overrun: 10 pulses after a latch -> pulses 9 and 10 keep data_out=0, bit_idx stays 8, and no second frame_done.
- Latch/pulse collision: raise pulse_in on the same clk as latch_in after 3 shifts -> bit_idx=0, sr reloaded, no shift counted.
- Idle/abort: IDLE_TIMEOUT=100 and no latch for 100 cycles -> pad_idle=1; next latch -> pad_idle=0 within 3 cycles. rst pulse mid-frame at bit_idx=4 -> data_out=1 and bit_idx=0 immediately.
